// File: rtl/l2_sink_d_pkg.sv
// l2_sink_d_pkg: shared constants for the L2 refill-response sink.
//   OP_BITS / SOURCE_BITS / DATA_BITS : D-channel opcode, source and line widths
//   OP_ACCESS_ACK / OP_ACCESS_ACK_DATA : accepted D-channel opcodes
//   ST_IDLE / ST_COLLECT / ST_DELIVER  : sink FSM state encoding
package l2_sink_d_pkg;
    localparam int OP_BITS     = 3;
    localparam int SOURCE_BITS = 4;
    localparam int DATA_BITS   = 128;
    localparam logic [OP_BITS-1:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [OP_BITS-1:0] OP_ACCESS_ACK_DATA = 3'd1;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;
endpackage

// File: rtl/l2_sink_d.sv
// l2_sink_d: reassembles D-channel beats into a cache line and pulses the owning MSHR.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mem_d_*_i / _ready_o: memory-side D beat handshake and payload
//   mshr_valid_i        : per-MSHR allocated flags, sampled while delivering
//   sinked_valid_o      : one-hot, one-cycle delivery pulse
//   sinked_opcode_o/source_o/data_o : latched response held until the next burst
//   err_o               : sticky protocol error (unknown opcode, burst mismatch, unallocated MSHR)
module l2_sink_d
    import l2_sink_d_pkg::*;
#(
    parameter int NUM_MSHR  = 4,
    parameter int LINE_BITS = DATA_BITS,
    parameter int BEAT_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_d_valid_i,
    output logic                   mem_d_ready_o,
    input  logic [OP_BITS-1:0]     mem_d_opcode_i,
    input  logic [SOURCE_BITS-1:0] mem_d_source_i,
    input  logic [BEAT_BITS-1:0]   mem_d_data_i,
    input  logic [NUM_MSHR-1:0]    mshr_valid_i,
    output logic [NUM_MSHR-1:0]    sinked_valid_o,
    output logic [OP_BITS-1:0]     sinked_opcode_o,
    output logic [SOURCE_BITS-1:0] sinked_source_o,
    output logic [LINE_BITS-1:0]   sinked_data_o,
    output logic                   err_o
);
    localparam int IDX_BITS = $clog2(NUM_MSHR);
    localparam int BEATS    = LINE_BITS / BEAT_BITS;
    localparam int CNT_BITS = $clog2(BEATS) + 1;

    logic [1:0]             state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [OP_BITS-1:0]     op_q, op_d;
    logic [SOURCE_BITS-1:0] src_q, src_d;
    logic [LINE_BITS-1:0]   data_q, data_d;
    logic                   err_q, err_d;
    logic [IDX_BITS-1:0]    idx;
    logic                   acc;

    assign idx           = src_q[IDX_BITS-1:0];
    assign mem_d_ready_o = (state_q != ST_DELIVER);
    assign acc           = mem_d_valid_i && mem_d_ready_o;

    assign sinked_valid_o  = (state_q == ST_DELIVER && mshr_valid_i[idx]) ? (NUM_MSHR'(1) << idx) : '0;
    assign sinked_opcode_o = op_q;
    assign sinked_source_o = src_q;
    assign sinked_data_o   = data_q;
    assign err_o           = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        src_d   = src_q;
        data_d  = data_q;
        err_d   = err_q;
        if (state_q == ST_IDLE && acc) begin
            if (mem_d_opcode_i == OP_ACCESS_ACK) begin
                op_d    = mem_d_opcode_i;
                src_d   = mem_d_source_i;
                data_d  = '0;
                state_d = ST_DELIVER;
            end else if (mem_d_opcode_i == OP_ACCESS_ACK_DATA) begin
                op_d    = mem_d_opcode_i;
                src_d   = mem_d_source_i;
                data_d  = LINE_BITS'(mem_d_data_i);
                cnt_d   = (BEATS == 1) ? '0 : CNT_BITS'(1);
                state_d = (BEATS == 1) ? ST_DELIVER : ST_COLLECT;
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == ST_COLLECT && acc) begin
            // Constant-offset selects per beat slot keep the write index narrow.
            for (int b = 0; b < BEATS; b++)
                if (cnt_q == CNT_BITS'(b)) data_d[b*BEAT_BITS +: BEAT_BITS] = mem_d_data_i;
            if (mem_d_source_i != src_q || mem_d_opcode_i != op_q) err_d = 1'b1;
            if (cnt_q == CNT_BITS'(BEATS - 1)) begin
                cnt_d   = '0;
                state_d = ST_DELIVER;
            end else begin
                cnt_d = cnt_q + CNT_BITS'(1);
            end
        end else if (state_q == ST_DELIVER) begin
            if (!mshr_valid_i[idx]) err_d = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            src_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            src_q   <= src_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
endmodule
